// File: rtl/fpga_torch_mem_pkg.sv
// Shared definitions for the FPGA torch memory subsystem.
//   M10K_ADDR_W / M10K_DATA_W : native M10K port widths
//   mem_req_t                 : one requester's access descriptor
//   arb_state_t               : arbiter ownership state
package fpga_torch_mem_pkg;

  localparam int unsigned M10K_ADDR_W = 8;
  localparam int unsigned M10K_DATA_W = 32;

  typedef struct packed {
    logic                   write;
    logic                   lock;
    logic [M10K_ADDR_W-1:0] addr;
    logic [M10K_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority picker.
//   i_req        : request vector
//   i_last_grant : index granted most recently; its successor has top priority
//   o_grant      : one-hot grant (all zero when no request)
//   o_any        : at least one request was granted
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_any
);

  // First pass looks only above last_grant, second pass wraps to the bottom.
  always_comb begin
    int unsigned w_last;
    w_last  = 32'(i_last_grant);
    o_grant = '0;
    o_any   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!o_any && i_req[i] && (i > w_last)) begin
        o_grant[i] = 1'b1;
        o_any      = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!o_any && i_req[i]) begin
        o_grant[i] = 1'b1;
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m10k_arbiter.sv
// Round-robin arbiter sharing one M10K port among NUM_REQ requesters.
// A requester transferring with req_lock=1 keeps exclusive ownership until it
// transfers with req_lock=0. Read data is routed back to the issuing requester
// READ_LATENCY cycles after issue, in issue order.
//   clock, reset_n          : posedge clock, synchronous active-low reset
//   req_valid/write/lock    : per-requester request controls (NUM_REQ bits)
//   req_addr / req_wdata    : per-requester address / write data, packed flat
//   req_ready               : one-hot grant, combinational
//   rsp_valid / rsp_data    : read return, one-hot valid plus shared data
//   mem_*                   : M10K port (byteenable tied to all ones)
module m10k_arbiter
  import fpga_torch_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_W       = M10K_ADDR_W,
  parameter int unsigned DATA_W       = M10K_DATA_W,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mem_chipselect,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_writedata,
  output logic [3:0]                mem_byteenable,
  input  logic [DATA_W-1:0]         mem_readdata
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t        r_state, w_state_nxt;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   r_owner, w_owner_nxt;
  logic [ID_W-1:0]   w_win_id;
  logic [NUM_REQ-1:0] w_rr_grant, w_grant;
  logic              w_rr_any, w_xfer, w_rd;

  // Read-return tracker: entry 0 is filled on issue, the last entry lines up
  // with mem_readdata.
  logic              r_sr_vld [READ_LATENCY];
  logic [ID_W-1:0]   r_sr_id  [READ_LATENCY];

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_rr_grant),
    .o_any        (w_rr_any)
  );

  always_comb begin
    w_grant     = '0;
    w_xfer      = 1'b0;
    w_win_id    = '0;
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    if (reset_n) begin
      if (r_state == UNLOCKED) begin
        w_grant = w_rr_grant;
        w_xfer  = w_rr_any;
      end else begin
        w_grant = req_valid & (NUM_REQ'(1) << r_owner);
        w_xfer  = |w_grant;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_win_id = ID_W'(i);
    end
    if (w_xfer) begin
      if (r_state == UNLOCKED) begin
        if (req_lock[w_win_id]) begin
          w_state_nxt = LOCKED;
          w_owner_nxt = w_win_id;
        end
      end else if (!req_lock[w_win_id]) begin
        w_state_nxt = UNLOCKED;
      end
    end
  end

  assign req_ready = w_grant;

  always_comb begin
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        mem_write     = req_write[i];
        mem_address   = req_addr[i*ADDR_W +: ADDR_W];
        mem_writedata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign mem_chipselect = w_xfer;
  assign mem_byteenable = 4'hF;
  assign w_rd           = w_xfer & ~mem_write;

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (reset_n && r_sr_vld[READ_LATENCY-1]) begin
      rsp_valid[r_sr_id[READ_LATENCY-1]] = 1'b1;
      rsp_data                           = mem_readdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= UNLOCKED;
      r_owner      <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        r_sr_vld[i] <= 1'b0;
        r_sr_id[i]  <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      if (w_xfer) r_last_grant <= w_win_id;
      r_sr_vld[0] <= w_rd;
      r_sr_id[0]  <= w_win_id;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        r_sr_vld[i] <= r_sr_vld[i-1];
        r_sr_id[i]  <= r_sr_id[i-1];
      end
    end
  end

endmodule
